// File: rtl/rram_pkg.sv
// Shared types and defaults for the RRAM read-capture path.
package rram_pkg;

  localparam int unsigned DefBSize = 4;
  localparam int unsigned DefXSize = 3;
  localparam int unsigned DefYSize = 5;

  typedef struct packed {
    logic [DefYSize+DefXSize-1:0] addr;
    logic                         err;
    logic [DefBSize-1:0]          data;
  } capture_entry_t;

  localparam int unsigned CaptureEntryW = $bits(capture_entry_t);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StSense = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rram_rd_fifo2.sv
// Two-entry valid/ready FIFO; a push into a full FIFO without a pop is dropped and flagged.
module rram_rd_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic [Width-1:0] head_data_o,
  output logic             head_valid_o,
  output logic             drop_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop, full, accept;

  assign pop    = (count_q != 2'd0) && pop_ready_i;
  assign full   = (count_q == 2'd2);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = ~wr_ptr_q;
    if (pop)    rd_ptr_d = ~rd_ptr_q;
    if (accept && !pop)      count_d = count_q + 2'd1;
    else if (!accept && pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data_o  = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != 2'd0);

endmodule

// File: rtl/rram_read_capture.sv
// Follows the controller's READ/PRE/EN_SA sequence, samples the latch SA after it settles,
// and queues {addr, err, data} for the host.
module rram_read_capture
  import rram_pkg::*;
#(
  parameter int unsigned B_SIZE        = DefBSize,
  parameter int unsigned X_SIZE        = DefXSize,
  parameter int unsigned Y_SIZE        = DefYSize,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     READ,
  input  logic                     PRE,
  input  logic                     EN_SA,
  input  logic [X_SIZE-1:0]        X_ADDRESS_IN,
  input  logic [Y_SIZE-1:0]        Y_ADDRESS_IN,
  input  logic [B_SIZE-1:0]        SA_OUT,
  input  logic [B_SIZE-1:0]        SA_OUT_B,
  output logic [B_SIZE-1:0]        DOUT,
  output logic [X_SIZE+Y_SIZE-1:0] DOUT_ADDR,
  output logic                     DOUT_ERR,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic                     OVERFLOW
);

  localparam int unsigned AddrW  = X_SIZE + Y_SIZE;
  localparam int unsigned EntryW = AddrW + 1 + B_SIZE;
  localparam int unsigned CntW   = 4;

  rd_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AddrW-1:0]  tag_q, tag_d;
  logic              en_sa_q;
  logic              ovf_q;
  logic              push, drop, sa_err;
  logic [EntryW-1:0] push_entry, head_entry;

  // A pair is resolved only when the true and complement outputs differ.
  assign sa_err     = |(~(SA_OUT ^ SA_OUT_B));
  assign push_entry = {tag_q, sa_err, SA_OUT};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (READ && PRE) begin
          state_d = StArmed;
          tag_d   = {Y_ADDRESS_IN, X_ADDRESS_IN};
        end
      end
      StArmed: begin
        if (!READ) begin
          state_d = StIdle;
        end else if (EN_SA && !en_sa_q) begin
          state_d = StSense;
          cnt_d   = CntW'(SETTLE_CYCLES - 1);
        end
      end
      StSense: begin
        if (cnt_q == '0 && EN_SA && READ) begin
          push    = 1'b1;
          state_d = StIdle;
        end else if (!EN_SA || !READ) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tag_q   <= '0;
      en_sa_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      en_sa_q <= EN_SA;
      ovf_q   <= ovf_q | drop;
    end
  end

  rram_rd_fifo2 #(
    .Width(EntryW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_ready_i (DOUT_READY),
    .head_data_o (head_entry),
    .head_valid_o(DOUT_VALID),
    .drop_o      (drop)
  );

  assign {DOUT_ADDR, DOUT_ERR, DOUT} = head_entry;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_rram_read_capture.sv
// Randomized read sequences checked every cycle against a queue model of the capture path.
module tb_rram_read_capture;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       READ = 1'b0, PRE = 1'b0, EN_SA = 1'b0, DOUT_READY = 1'b0;
  logic [2:0] X_ADDRESS_IN = '0;
  logic [4:0] Y_ADDRESS_IN = '0;
  logic [3:0] SA_OUT = '0, SA_OUT_B = '0;
  logic [3:0] DOUT;
  logic [7:0] DOUT_ADDR;
  logic       DOUT_ERR, DOUT_VALID, OVERFLOW;

  rram_read_capture #(
    .B_SIZE(4), .X_SIZE(3), .Y_SIZE(5), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .READ(READ), .PRE(PRE), .EN_SA(EN_SA),
    .X_ADDRESS_IN(X_ADDRESS_IN), .Y_ADDRESS_IN(Y_ADDRESS_IN),
    .SA_OUT(SA_OUT), .SA_OUT_B(SA_OUT_B), .DOUT(DOUT), .DOUT_ADDR(DOUT_ADDR),
    .DOUT_ERR(DOUT_ERR), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .OVERFLOW(OVERFLOW)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] addr;
    logic       err;
    logic [3:0] data;
  } exp_t;

  int   total = 0, bad = 0, cyc = 0;
  bit   rnd_ready = 1'b0;
  bit   movf = 1'b0;
  exp_t sched[$];
  exp_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: pop if the host is ready and something is queued, then apply any capture due now.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      if (mq.size() > 0 && DOUT_READY) e = mq.pop_front();
      if (sched.size() > 0 && sched[0].edge_no == cyc) begin
        e = sched.pop_front();
        if (mq.size() < 2) mq.push_back(e);
        else movf = 1'b1;
      end
      #1;
      if (reset) begin
        check("valid", DOUT_VALID, mq.size() > 0);
        if (mq.size() > 0) begin
          check("data", DOUT, mq[0].data);
          check("addr", DOUT_ADDR, mq[0].addr);
          check("err", DOUT_ERR, mq[0].err);
        end
        check("overflow", OVERFLOW, movf);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (rnd_ready) DOUT_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      READ = 1'b0; PRE = 1'b0; EN_SA = 1'b0;
    end
  endtask

  // Arm, wait gap cycles, then hold EN_SA high for h cycles; a capture needs h > S.
  task automatic do_read(input logic [4:0] y, input logic [2:0] x, input logic [3:0] sa,
                         input logic [3:0] sab, input int gap, input int h);
    exp_t e;
    step();
    READ = 1'b1; PRE = 1'b1; EN_SA = 1'b0; Y_ADDRESS_IN = y; X_ADDRESS_IN = x;
    repeat (gap) begin
      step();
      PRE = 1'b0; Y_ADDRESS_IN = 5'($urandom); X_ADDRESS_IN = 3'($urandom);
    end
    step();
    PRE = 1'b0; EN_SA = 1'b1; SA_OUT = sa; SA_OUT_B = sab;
    Y_ADDRESS_IN = 5'($urandom); X_ADDRESS_IN = 3'($urandom);
    if (h >= int'(S) + 1) begin
      e.edge_no = cyc + 1 + int'(S);
      e.addr    = {y, x};
      e.err     = 1'b0;
      for (int i = 0; i < 4; i++) if (sa[i] == sab[i]) e.err = 1'b1;
      e.data    = sa;
      sched.push_back(e);
    end
    repeat (h - 1) step();
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_dout", DOUT, 0);
    check("rst_addr", DOUT_ADDR, 0);
    check("rst_err", DOUT_ERR, 0);
    check("rst_valid", DOUT_VALID, 0);
    check("rst_ovf", OVERFLOW, 0);
    step();
    reset = 1'b1;

    // Single read and latency
    do_read(5'd3, 3'd6, 4'hA, 4'h5, 1, S + 1);
    check("lat_before", DOUT_VALID, 0);
    idle(1);
    check("single_valid", DOUT_VALID, 1);
    check("single_dout", DOUT, 4'hA);
    check("single_addr", DOUT_ADDR, 8'h1E);
    check("single_err", DOUT_ERR, 0);
    idle(1);
    check("hold_dout", DOUT, 4'hA);
    DOUT_READY = 1'b1; idle(1); DOUT_READY = 1'b0;
    check("single_popped", DOUT_VALID, 0);

    // Unresolved bit pair
    do_read(5'd9, 3'd1, 4'hA, 4'h7, 0, S + 1);
    idle(1);
    check("unres_err", DOUT_ERR, 1);
    check("unres_dout", DOUT, 4'hA);
    check("unres_addr", DOUT_ADDR, 8'h49);
    DOUT_READY = 1'b1; idle(1); DOUT_READY = 1'b0;

    // Full FIFO with a pop coinciding with the capture
    do_read(5'd1, 3'd1, 4'h4, 4'hB, 0, S + 1);
    do_read(5'd2, 3'd2, 4'h5, 4'hA, 0, S + 1);
    do_read(5'd3, 3'd3, 4'h6, 4'h9, 0, S + 1);
    check("full_head", DOUT, 4'h4);
    DOUT_READY = 1'b1;
    idle(1);
    check("simul_second", DOUT, 4'h5);
    check("simul_no_ovf", OVERFLOW, 0);
    idle(1);
    check("simul_new", DOUT, 4'h6);
    idle(1);
    check("simul_empty", DOUT_VALID, 0);
    DOUT_READY = 1'b0;

    // Backpressure and overflow
    do_read(5'd0, 3'd1, 4'h1, 4'hE, 0, S + 1);
    do_read(5'd0, 3'd2, 4'h2, 4'hD, 0, S + 1);
    do_read(5'd0, 3'd3, 4'h3, 4'hC, 0, S + 1);
    idle(1);
    check("ovf_set", OVERFLOW, 1);
    check("ovf_head", DOUT, 4'h1);
    DOUT_READY = 1'b1;
    idle(1);
    check("ovf_second", DOUT, 4'h2);
    idle(1);
    check("ovf_drained", DOUT_VALID, 0);
    check("ovf_sticky", OVERFLOW, 1);
    DOUT_READY = 1'b0;

    // Aborts: EN_SA drops before the sample point
    do_read(5'd4, 3'd4, 4'hF, 4'h0, 0, 1);
    idle(2);
    check("abort1_none", DOUT_VALID, 0);
    do_read(5'd4, 3'd5, 4'hF, 4'h0, 0, S);
    idle(2);
    check("abort2_none", DOUT_VALID, 0);
    do_read(5'd4, 3'd6, 4'h3, 4'hC, 0, S + 1);
    idle(1);
    check("after_abort_dout", DOUT, 4'h3);
    check("after_abort_addr", DOUT_ADDR, 8'h26);
    DOUT_READY = 1'b1; idle(1); DOUT_READY = 1'b0;

    // Asynchronous reset while a capture is still settling
    do_read(5'd5, 3'd5, 4'h8, 4'h7, 0, S + 1);
    do_read(5'd7, 3'd7, 4'h9, 4'h6, 0, S + 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dout", DOUT, 0);
    check("mid_rst_addr", DOUT_ADDR, 0);
    check("mid_rst_valid", DOUT_VALID, 0);
    check("mid_rst_ovf", OVERFLOW, 0);
    sched.delete(); mq.delete(); movf = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step();
    idle(2);
    check("no_stale_push", DOUT_VALID, 0);

    // Randomized traffic
    rnd_ready = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          step();
          READ = 1'b0; PRE = 1'($urandom); EN_SA = 1'($urandom);
          Y_ADDRESS_IN = 5'($urandom); X_ADDRESS_IN = 3'($urandom);
        end
        idle(1);
      end else begin
        int         h;
        logic [3:0] sa, sab;
        h   = $urandom_range(1, S + 2);
        sa  = 4'($urandom);
        sab = ~sa;
        if ($urandom_range(0, 3) == 0) sab[$urandom_range(0, 3)] ^= 1'b1;
        do_read(5'($urandom), 3'($urandom), sa, sab, $urandom_range(0, 2), h);
        if (h <= int'(S)) idle($urandom_range(1, 2));
        else idle($urandom_range(0, 2));
      end
    end
    rnd_ready = 1'b0;
    DOUT_READY = 1'b1;
    idle(4);
    check("final_drained", DOUT_VALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
